// File: rtl/fetch_pkg.sv
// Shared widths and polarity constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstDataWidth = 32;
    localparam logic        HoldEnable    = 1'b1;
    localparam logic        RstEnable     = 1'b1;
    localparam int unsigned PcStep        = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry capture/replay register for memory data that returns while IF/ID is held.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrWidth,
    parameter int unsigned INST_W = InstDataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [INST_W-1:0] rdata,
    output logic              skid_valid,
    output logic [ADDR_W-1:0] skid_pc,
    output logic [INST_W-1:0] skid_inst
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
        end else if (flush) begin
            // Younger data behind a branch delay slot is squashed.
            skid_valid <= 1'b0;
        end else if (hold) begin
            if (!skid_valid && req_valid) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_inst  <= rdata;
            end
        end else if (skid_valid) begin
            // Entry drains into IF/ID; refill from memory in the same cycle if data returns.
            if (req_valid) begin
                skid_pc   <= req_pc;
                skid_inst <= rdata;
            end else begin
                skid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, 1-cycle synchronous imem requests, skid buffer and IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = InstAddrWidth,
    parameter int unsigned       INST_W   = InstDataWidth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_hold_IF,
    input  logic              is_hold_IF_ID,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_ce,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_ID,
    output logic [INST_W-1:0] inst_ID,
    output logic              valid_ID
);

    logic [ADDR_W-1:0] pc_if;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              held_if;
    logic              held_id;
    logic              branch_eff;
    logic              avail_valid;
    logic [ADDR_W-1:0] avail_pc;
    logic [INST_W-1:0] avail_inst;

    assign held_if    = (is_hold_IF == HoldEnable);
    assign held_id    = (is_hold_IF_ID == HoldEnable);
    assign branch_eff = branch_taken & ~held_id;
    assign imem_addr  = pc_if;

    // While IF/ID is held, at most one entry may be in flight or parked in the skid.
    assign imem_ce = (rst != RstEnable) & ~held_if & ~branch_eff
                   & ~(held_id & (skid_valid | req_valid));

    always_comb begin
        avail_valid = 1'b0;
        avail_pc    = req_pc;
        avail_inst  = imem_rdata;
        if (skid_valid) begin
            avail_valid = 1'b1;
            avail_pc    = skid_pc;
            avail_inst  = skid_inst;
        end else if (req_valid) begin
            avail_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc_if     <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else if (branch_eff) begin
            pc_if     <= branch_target;
            req_valid <= 1'b0;
        end else if (imem_ce) begin
            pc_if     <= pc_if + ADDR_W'(PcStep);
            req_valid <= 1'b1;
            req_pc    <= pc_if;
        end else begin
            req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc_ID    <= '0;
            inst_ID  <= '0;
            valid_ID <= 1'b0;
        end else if (!held_id) begin
            valid_ID <= avail_valid;
            if (avail_valid) begin
                pc_ID   <= avail_pc;
                inst_ID <= avail_inst;
            end
        end
    end

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .hold       (held_id),
        .flush      (branch_eff),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .rdata      (imem_rdata),
        .skid_valid (skid_valid),
        .skid_pc    (skid_pc),
        .skid_inst  (skid_inst)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based program-order model plus directed scenarios.
module tb_fetch_stage;

    localparam logic [31:0] BUB  = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_if = 1'b0;
    logic        hold_id = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        imem_ce;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = IDLE;
    logic [31:0] pc_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: fetched-but-not-delivered addresses in program order.
    logic [31:0] m_pend[$];
    logic [31:0] m_fetch_pc;
    logic        m_id_valid;
    logic [31:0] m_id_pc;
    logic        m_iss;

    logic [31:0] hist[$];
    logic [31:0] exp_q[$];
    logic        ce_s;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .is_hold_IF    (hold_if),
        .is_hold_IF_ID (hold_id),
        .branch_taken  (br),
        .branch_target (tgt),
        .imem_ce       (imem_ce),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_ID         (pc_ID),
        .inst_ID       (inst_ID),
        .valid_ID      (valid_ID)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    function automatic logic exp_ce();
        return !hold_if && !(br && !hold_id) && !(hold_id && m_pend.size() != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend.delete();
            m_fetch_pc = 32'h0;
            m_id_valid = 1'b0;
            m_id_pc    = 32'h0;
        end else begin
            m_iss = exp_ce();
            if (!hold_id) begin
                if (m_pend.size() != 0) begin
                    m_id_valid = 1'b1;
                    m_id_pc    = m_pend.pop_front();
                end else begin
                    m_id_valid = 1'b0;
                end
                if (br) begin
                    m_pend.delete();
                    m_fetch_pc = tgt;
                end
            end
            if (m_iss) begin
                m_pend.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("imem_ce", {31'b0, imem_ce}, {31'b0, exp_ce()});
            chk("imem_addr", imem_addr, m_fetch_pc);
            chk("valid_ID", {31'b0, valid_ID}, {31'b0, m_id_valid});
            if (m_id_valid) begin
                chk("pc_ID", pc_ID, m_id_pc);
                chk("inst_ID", inst_ID, mem(m_id_pc));
            end
            hist.push_back(valid_ID ? pc_ID : BUB);
        end
    end

    task automatic step(input logic hif, input logic hid, input logic b,
                        input logic [31:0] t, output logic ce_o);
        logic [31:0] a;
        hold_if = hif;
        hold_id = hid;
        br      = b;
        tgt     = t;
        @(negedge clk);
        ce_o = imem_ce;
        a    = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = ce_o ? mem(a) : IDLE;
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, ce_s);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        hold_if    = 1'b0;
        hold_id    = 1'b0;
        br         = 1'b0;
        tgt        = 32'h0;
        imem_rdata = IDLE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic check_hist(input string name, input int start);
        logic [31:0] act;
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (start + i < hist.size()) ? hist[start + i] : 32'hBAD0_0000;
            chk($sformatf("%s[%0d]", name, i), act, exp_q[i]);
        end
    endtask

    initial begin
        // Free-running fetch from reset.
        do_reset();
        chk("reset_valid_ID", {31'b0, valid_ID}, 32'h0);
        chk("reset_pc_ID", pc_ID, 32'h0);
        chk("reset_inst_ID", inst_ID, 32'h0);
        run_free(7);
        exp_q = '{BUB, BUB, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        check_hist("free", 0);

        // Load-use stall: both holds for one cycle while pc_ID=0x8.
        do_reset();
        run_free(4);
        step(1'b1, 1'b1, 1'b0, 32'h0, ce_s);
        run_free(4);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14};
        check_hist("load_use", 2);

        // Three-cycle stall.
        do_reset();
        run_free(4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, ce_s);
            chk($sformatf("stall3_ce%0d", i), {31'b0, ce_s}, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, ce_s);
        chk("stall3_release_ce", {31'b0, ce_s}, 32'h1);
        run_free(3);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14};
        check_hist("stall3", 2);

        // Taken branch at pc_ID=0x10.
        do_reset();
        run_free(6);
        step(1'b0, 1'b0, 1'b1, 32'h100, ce_s);
        chk("branch_ce", {31'b0, ce_s}, 32'h0);
        run_free(5);
        exp_q = '{32'h10, 32'h14, BUB, 32'h100, 32'h104, 32'h108};
        check_hist("branch", 6);

        // Branch on the cycle right after a stall; delay slot comes from the skid.
        do_reset();
        run_free(6);
        step(1'b1, 1'b1, 1'b0, 32'h0, ce_s);
        step(1'b0, 1'b0, 1'b1, 32'h100, ce_s);
        run_free(4);
        exp_q = '{32'h10, 32'h10, 32'h14, BUB, 32'h100, 32'h104};
        check_hist("skid_branch", 6);

        // Asynchronous reset during a hold with the skid full.
        do_reset();
        run_free(5);
        step(1'b1, 1'b1, 1'b0, 32'h0, ce_s);
        hold_if = 1'b1;
        hold_id = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid_ID", {31'b0, valid_ID}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid_ID", {31'b0, valid_ID}, 32'h0);
        chk("async_rst_pc_ID", pc_ID, 32'h0);
        chk("async_rst_inst_ID", inst_ID, 32'h0);
        chk("async_rst_ce", {31'b0, imem_ce}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        hold_if    = 1'b0;
        hold_id    = 1'b0;
        imem_rdata = IDLE;
        rst        = 1'b0;
        hist.delete();
        run_free(5);
        exp_q = '{BUB, BUB, 32'h0, 32'h4, 32'h8};
        check_hist("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
